analyzer_sequencer: RTL and testbench
=====================================

Name: analyzer_sequencer

Overview:
- Upstream/downstream wrapper stage for the number analyzer.
- Accepts 32-bit numbers from a valid/ready stream and launches one analysis per number with a one-cycle go pulse and a stable operand.
- Collects the even, Fibonacci and palindrome verdicts as each sub-analyzer reports done.
- Presents one packed result per number on a valid/ready output stream, with a timeout guard against stuck analyzers.

Parameters:
- DATA_W, 32, operand width driven to the analyzer.
- TIMEOUT_CYCLES, 1024, maximum WAIT cycles before the result is forced out; legal range 2..65535.
- CNT_W, 16, width of the processed and timeout counters.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- num_valid_i  input  1  upstream operand valid.
- num_ready_o  output  1  sequencer can accept an operand.
- num_i  input  DATA_W  operand.
- go_o  output  1  one-cycle launch pulse to the analyzer's go input.
- inp_o  output  DATA_W  operand to the analyzer; stable from LAUNCH until the result is accepted.
- even_done_i, fib_done_i, pal_done_i  input  1 each  per-analyzer completion, level or pulse.
- is_even_i, is_fib_i, is_pal_i  input  1 each  verdicts; valid while the matching done is high.
- res_valid_o  output  1  result available.
- res_ready_i  input  1  downstream accepts the result.
- res_num_o  output  DATA_W  operand the result belongs to.
- res_flags_o  output  3  {pal, fib, even}.
- res_timeout_o  output  1  result was forced by timeout.
- processed_cnt_o  output  CNT_W  results accepted downstream; saturating.
- timeout_cnt_o  output  CNT_W  results with timeout set; saturating.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0: num_ready_o, go_o, inp_o, res_*, and both counters.
  - Done latches and the wait counter are cleared.
  - Reset asserted mid-operation abandons the analysis without emitting a result.
- FSM has four states:
  - IDLE:
    - num_ready_o=1.
    - When num_valid_i & num_ready_o, latch num_i into inp_o and res_num_o, then go to LAUNCH.
  - LAUNCH (exactly 1 cycle):
    - go_o=1 and num_ready_o=0.
    - Clear done latches, flag latches and the wait counter.
    - Go to WAIT.
  - WAIT:
    - Each cycle, for each analyzer whose done_i=1 and whose latch is clear, set its done latch and capture its verdict.
    - Done inputs are ignored in LAUNCH; only the first done per analyzer is captured.
    - When all three latches are set, including latches set in this same cycle, go to OUT with res_timeout_o=0.
    - Otherwise increment the wait counter. When it reaches TIMEOUT_CYCLES-1, go to OUT with res_timeout_o=1. Flags of analyzers that never reported are 0; flags already captured are kept.
  - OUT:
    - res_valid_o=1. res_num_o, res_flags_o and res_timeout_o are held stable until res_valid_o & res_ready_i.
    - On acceptance, return to IDLE with res_valid_o=0 the next cycle.
    - On acceptance, processed_cnt_o increments, and timeout_cnt_o increments if res_timeout_o=1.
    - Both counters saturate at all-ones.
- Latency: operand accepted at edge T → go_o high in cycle T+1 → earliest res_valid_o at T+3, when all dones arrive in the first WAIT cycle.
- Throughput is one number in flight. num_ready_o=0 in every state except IDLE. No skid buffer.
- res_ready_i held high before res_valid_o has no effect. A result is never dropped while res_ready_i=0.
- go_o is never asserted outside LAUNCH.

Optional Feature:
- Macro: ANALYZER_SEQ_STATS_EN.
- When defined, adds outputs even_cnt_o, fib_cnt_o and pal_cnt_o (CNT_W each, saturating, reset to 0).
  - Each counter increments when a result is accepted downstream with the corresponding flag = 1.
  - Timed-out results are counted as well, but only for the flags that were actually captured.
- When undefined, these ports and their logic are absent and all other behaviour is identical.

Test Plan:
- Reset held low, then released; push 32'd8 with all three dones asserted in the first WAIT cycle with is_even=1, is_fib=1, is_pal=0 → go_o is a single pulse at T+1, res_valid_o at T+3, res_flags_o=3'b011, res_timeout_o=0, processed_cnt_o=1 after acceptance.
- Push 32'd121 with dones arriving staggered at WAIT cycles 2, 5 and 9 (pal=1, fib=0, even=0) → res_valid_o one cycle after the last done, flags=3'b100, each verdict captured only on its first done.
- TIMEOUT_CYCLES=8; fib_done_i is never asserted; the even and pal dones arrive with verdict 1 → res_valid_o after 8 WAIT cycles, flags=3'b101, res_timeout_o=1, timeout_cnt_o=1.
- Back-pressure: res_ready_i=0 for 20 cycles while num_valid_i stays high with a new operand → res_* stable throughout, num_ready_o=0, go_o=0; after acceptance the next operand is accepted in IDLE.
- Reset pulled low during WAIT → all outputs 0 immediately, no result emitted, processed_cnt_o unchanged at 0; a fresh operand afterwards completes normally.
- Counter saturation with CNT_W=2: accept 5 results → processed_cnt_o=3. With ANALYZER_SEQ_STATS_EN, 5 even results → even_cnt_o=3.

Source files
------------

// File: rtl/analyzer_sequencer_if.sv
// Operand/result stream bundle between the number analyzer sequencer and its
// surroundings. The master modport is the sequencer side.
// Optional stats counters are present only with ANALYZER_SEQ_STATS_EN defined.
interface analyzer_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  // upstream operand stream
  logic              num_valid_i;
  logic              num_ready_o;
  logic [DATA_W-1:0] num_i;
  // analyzer launch and completion
  logic              go_o;
  logic [DATA_W-1:0] inp_o;
  logic              even_done_i;
  logic              fib_done_i;
  logic              pal_done_i;
  logic              is_even_i;
  logic              is_fib_i;
  logic              is_pal_i;
  // downstream result stream
  logic              res_valid_o;
  logic              res_ready_i;
  logic [DATA_W-1:0] res_num_o;
  logic [2:0]        res_flags_o;
  logic              res_timeout_o;
  // counters
  logic [CNT_W-1:0]  processed_cnt_o;
  logic [CNT_W-1:0]  timeout_cnt_o;
`ifdef ANALYZER_SEQ_STATS_EN
  logic [CNT_W-1:0]  even_cnt_o;
  logic [CNT_W-1:0]  fib_cnt_o;
  logic [CNT_W-1:0]  pal_cnt_o;
`endif

  modport master (
    input  num_valid_i, num_i, even_done_i, fib_done_i, pal_done_i,
           is_even_i, is_fib_i, is_pal_i, res_ready_i,
    output num_ready_o, go_o, inp_o, res_valid_o, res_num_o, res_flags_o,
           res_timeout_o, processed_cnt_o, timeout_cnt_o
`ifdef ANALYZER_SEQ_STATS_EN
    , output even_cnt_o, fib_cnt_o, pal_cnt_o
`endif
  );

  modport slave (
    output num_valid_i, num_i, even_done_i, fib_done_i, pal_done_i,
           is_even_i, is_fib_i, is_pal_i, res_ready_i,
    input  num_ready_o, go_o, inp_o, res_valid_o, res_num_o, res_flags_o,
           res_timeout_o, processed_cnt_o, timeout_cnt_o
`ifdef ANALYZER_SEQ_STATS_EN
    , input even_cnt_o, fib_cnt_o, pal_cnt_o
`endif
  );
endinterface

// File: rtl/analyzer_sequencer.sv
// Number analyzer sequencer: takes one operand at a time, pulses go to the
// analyzer, gathers the even/fib/pal verdicts on their first done, and emits
// one packed result per operand, forcing it out if an analyzer stalls.
// Optional per-flag result counters: define ANALYZER_SEQ_STATS_EN.
module analyzer_sequencer #(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input logic                  clk,
  input logic                  reset,
  analyzer_sequencer_if.master bus
);
  localparam logic [15:0]      WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {IDLE = 2'd0, LAUNCH = 2'd1, WAIT = 2'd2, OUT = 2'd3} state_t;

  state_t            state, stateNext;
  logic              readyQ;
  logic [DATA_W-1:0] operandQ;
  logic [2:0]        doneQ, flagQ;
  logic              timeoutQ;
  logic [15:0]       waitCnt;
  logic [CNT_W-1:0]  processedCnt, timeoutCnt;
  logic [2:0]        doneIn, verdictIn, newDone;
  logic              allDone, waitExpired, numAccept, resAccept;

  // decode of handshakes and done/verdict vectors, bit order {pal, fib, even}
  always_comb begin
    doneIn      = {bus.pal_done_i, bus.fib_done_i, bus.even_done_i};
    verdictIn   = {bus.is_pal_i, bus.is_fib_i, bus.is_even_i};
    newDone     = doneIn & ~doneQ;
    allDone     = &(doneQ | doneIn);
    waitExpired = (waitCnt == WAIT_LAST);
    numAccept   = (state == IDLE) && bus.num_valid_i && readyQ;
    resAccept   = (state == OUT) && bus.res_ready_i;
  end

  // next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (numAccept) stateNext = LAUNCH;
      LAUNCH:  stateNext = WAIT;
      WAIT:    if (allDone || waitExpired) stateNext = OUT;
      OUT:     if (bus.res_ready_i) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  // operand, done/flag latches and wait counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      readyQ   <= 1'b0;
      operandQ <= '0;
      doneQ    <= '0;
      flagQ    <= '0;
      timeoutQ <= 1'b0;
      waitCnt  <= '0;
    end else begin
      // registered so ready stays low while reset is asserted
      readyQ <= (stateNext == IDLE);
      case (state)
        IDLE: if (numAccept) operandQ <= bus.num_i;
        LAUNCH: begin
          doneQ    <= '0;
          flagQ    <= '0;
          timeoutQ <= 1'b0;
          waitCnt  <= '0;
        end
        WAIT: begin
          // only the first done of each analyzer captures its verdict
          doneQ <= doneQ | doneIn;
          flagQ <= (flagQ & ~newDone) | (verdictIn & newDone);
          if (!allDone) begin
            if (waitExpired) timeoutQ <= 1'b1;
            else             waitCnt  <= waitCnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // saturating result counters, stepped on downstream acceptance
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      processedCnt <= '0;
      timeoutCnt   <= '0;
    end else if (resAccept) begin
      if (processedCnt != CNT_MAX) processedCnt <= processedCnt + CNT_W'(1);
      if (timeoutQ && timeoutCnt != CNT_MAX) timeoutCnt <= timeoutCnt + CNT_W'(1);
    end
  end

`ifdef ANALYZER_SEQ_STATS_EN
  logic [2:0][CNT_W-1:0] statCnt;

  // per-flag saturating counters; timed-out results count only captured flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      statCnt <= '0;
    end else if (resAccept) begin
      for (int i = 0; i < 3; i++)
        if (flagQ[i] && statCnt[i] != CNT_MAX) statCnt[i] <= statCnt[i] + CNT_W'(1);
    end
  end

  assign bus.even_cnt_o = statCnt[0];
  assign bus.fib_cnt_o  = statCnt[1];
  assign bus.pal_cnt_o  = statCnt[2];
`endif

  assign bus.num_ready_o     = readyQ;
  assign bus.go_o            = (state == LAUNCH);
  assign bus.inp_o           = operandQ;
  assign bus.res_valid_o     = (state == OUT);
  assign bus.res_num_o       = operandQ;
  assign bus.res_flags_o     = flagQ;
  assign bus.res_timeout_o   = timeoutQ;
  assign bus.processed_cnt_o = processedCnt;
  assign bus.timeout_cnt_o   = timeoutCnt;
endmodule

// File: tb/tb_analyzer_sequencer.sv
// Bench for analyzer_sequencer. Two instances: A (TIMEOUT_CYCLES=16, CNT_W=16)
// for latency, staggered dones, back-pressure and reset; B (TIMEOUT_CYCLES=8,
// CNT_W=2) for timeout and counter saturation. Expected results are queued by
// the stimulus and checked by a separate monitor on each accepted result.
module tb_analyzer_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstN;
  int   checks = 0;
  int   failures = 0;

  // stimulus, index 0 = A, 1 = B
  logic        numValid[2], resReady[2];
  logic        evenDone[2], fibDone[2], palDone[2];
  logic        isEven[2], isFib[2], isPal[2];
  logic [31:0] num[2];
  // observed outputs
  logic        numReady[2], go[2], resValid[2], resTo[2];
  logic [31:0] inp[2], resNum[2];
  logic [2:0]  flags[2];
  logic [15:0] procCnt[2], toCnt[2];
`ifdef ANALYZER_SEQ_STATS_EN
  logic [15:0] evenCntB, fibCntB, palCntB;
`endif

  typedef struct packed {
    logic [31:0] num;
    logic [2:0]  flags;
    logic        to;
  } exp_t;
  exp_t expA[$];
  exp_t expB[$];

  analyzer_sequencer_if #(.DATA_W(32), .CNT_W(16)) ifA ();
  analyzer_sequencer_if #(.DATA_W(32), .CNT_W(2))  ifB ();

  analyzer_sequencer #(.DATA_W(32), .TIMEOUT_CYCLES(16), .CNT_W(16)) dutA (
    .clk(clk), .reset(rstN), .bus(ifA));
  analyzer_sequencer #(.DATA_W(32), .TIMEOUT_CYCLES(8), .CNT_W(2)) dutB (
    .clk(clk), .reset(rstN), .bus(ifB));

  assign ifA.num_valid_i = numValid[0];
  assign ifA.num_i       = num[0];
  assign ifA.res_ready_i = resReady[0];
  assign ifA.even_done_i = evenDone[0];
  assign ifA.fib_done_i  = fibDone[0];
  assign ifA.pal_done_i  = palDone[0];
  assign ifA.is_even_i   = isEven[0];
  assign ifA.is_fib_i    = isFib[0];
  assign ifA.is_pal_i    = isPal[0];
  assign ifB.num_valid_i = numValid[1];
  assign ifB.num_i       = num[1];
  assign ifB.res_ready_i = resReady[1];
  assign ifB.even_done_i = evenDone[1];
  assign ifB.fib_done_i  = fibDone[1];
  assign ifB.pal_done_i  = palDone[1];
  assign ifB.is_even_i   = isEven[1];
  assign ifB.is_fib_i    = isFib[1];
  assign ifB.is_pal_i    = isPal[1];

  assign numReady[0] = ifA.num_ready_o;
  assign go[0]       = ifA.go_o;
  assign inp[0]      = ifA.inp_o;
  assign resValid[0] = ifA.res_valid_o;
  assign resNum[0]   = ifA.res_num_o;
  assign flags[0]    = ifA.res_flags_o;
  assign resTo[0]    = ifA.res_timeout_o;
  assign procCnt[0]  = ifA.processed_cnt_o;
  assign toCnt[0]    = ifA.timeout_cnt_o;
  assign numReady[1] = ifB.num_ready_o;
  assign go[1]       = ifB.go_o;
  assign inp[1]      = ifB.inp_o;
  assign resValid[1] = ifB.res_valid_o;
  assign resNum[1]   = ifB.res_num_o;
  assign flags[1]    = ifB.res_flags_o;
  assign resTo[1]    = ifB.res_timeout_o;
  assign procCnt[1]  = 16'(ifB.processed_cnt_o);
  assign toCnt[1]    = 16'(ifB.timeout_cnt_o);
`ifdef ANALYZER_SEQ_STATS_EN
  assign evenCntB = 16'(ifB.even_cnt_o);
  assign fibCntB  = 16'(ifB.fib_cnt_o);
  assign palCntB  = 16'(ifB.pal_cnt_o);
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input int d, input logic [31:0] n, input logic [2:0] f, input logic t);
    exp_t e;
    e.num = n; e.flags = f; e.to = t;
    if (d == 0) expA.push_back(e);
    else        expB.push_back(e);
  endtask

  task automatic clearDones(input int d);
    evenDone[d] = 0; fibDone[d] = 0; palDone[d] = 0;
    isEven[d] = 0; isFib[d] = 0; isPal[d] = 0;
  endtask

  task automatic checkZero(input int d, input string tag);
    chk({tag, "_ctrl"}, {27'd0, numReady[d], go[d], resValid[d], resTo[d], 1'b0}, 32'd0);
    chk({tag, "_flags"}, {29'd0, flags[d]}, 32'd0);
    chk({tag, "_inp"}, inp[d], 32'd0);
    chk({tag, "_resnum"}, resNum[d], 32'd0);
    chk({tag, "_cnts"}, {procCnt[d], toCnt[d]}, 32'd0);
  endtask

  // offer an operand and wait (bounded) for the launch pulse; leaves us in LAUNCH
  task automatic send(input int d, input logic [31:0] v);
    int n = 0;
    numValid[d] = 1; num[d] = v;
    do begin tick(); n++; end while (!go[d] && n < 40);
    chk("accept_go", {31'd0, go[d]}, 32'd1);
    chk("accept_inp", inp[d], v);
    numValid[d] = 0;
  endtask

  // from LAUNCH: all dones in the first WAIT cycle; leaves us in OUT
  task automatic finishAll(input int d, input logic [31:0] v, input logic [2:0] f);
    tick();
    chk("go_single_pulse", {31'd0, go[d]}, 32'd0);
    evenDone[d] = 1; fibDone[d] = 1; palDone[d] = 1;
    isEven[d] = f[0]; isFib[d] = f[1]; isPal[d] = f[2];
    pushExp(d, v, f, 1'b0);
    tick();
    clearDones(d);
    chk("valid_at_t3", {31'd0, resValid[d]}, 32'd1);
  endtask

  task automatic accept(input int d);
    resReady[d] = 1;
    tick();
    resReady[d] = 0;
    chk("valid_drop", {31'd0, resValid[d]}, 32'd0);
  endtask

  // scoreboard monitor: compares every accepted result against the queue head
  always @(negedge clk) begin
    exp_t e;
    if (rstN) begin
      for (int d = 0; d < 2; d++) begin
        if (resValid[d] && resReady[d]) begin
          if ((d == 0 ? expA.size() : expB.size()) == 0) begin
            chk("unexpected_result", 32'd1, 32'd0);
          end else begin
            if (d == 0) e = expA.pop_front();
            else        e = expB.pop_front();
            chk("res_num", resNum[d], e.num);
            chk("res_flags", {29'd0, flags[d]}, {29'd0, e.flags});
            chk("res_timeout", {31'd0, resTo[d]}, {31'd0, e.to});
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rstN = 0;
    for (int d = 0; d < 2; d++) begin
      numValid[d] = 0; resReady[d] = 0; num[d] = 0;
      clearDones(d);
    end
    repeat (2) @(posedge clk);
    #1;
    checkZero(0, "rst_A");
    checkZero(1, "rst_B");
    rstN = 1;
    tick();
    chk("ready_after_reset", {31'd0, numReady[0]}, 32'd1);

    // basic: 8 -> even, fib
    send(0, 32'd8);
    finishAll(0, 32'd8, 3'b011);
    accept(0);
    chk("proc_after_1", {16'd0, procCnt[0]}, 32'd1);

    // staggered dones at WAIT 2/5/9, later dones and verdict changes ignored
    send(0, 32'd121);
    pushExp(0, 32'd121, 3'b100, 1'b0);
    resReady[0] = 1;
    tick();
    for (int w = 1; w <= 9; w++) begin
      palDone[0]  = (w >= 2);
      isPal[0]    = (w == 2);
      fibDone[0]  = (w == 5 || w == 7);
      isFib[0]    = (w == 7);
      evenDone[0] = (w == 9);
      isEven[0]   = 1'b0;
      chk("stagger_no_valid", {31'd0, resValid[0]}, 32'd0);
      tick();
    end
    clearDones(0);
    chk("stagger_valid", {31'd0, resValid[0]}, 32'd1);
    tick();
    resReady[0] = 0;
    chk("proc_after_2", {16'd0, procCnt[0]}, 32'd2);

    // back-pressure with a waiting operand
    send(0, 32'h1234_5678);
    tick();
    evenDone[0] = 1; fibDone[0] = 1; palDone[0] = 1;
    isEven[0] = 1; isFib[0] = 1; isPal[0] = 1;
    pushExp(0, 32'h1234_5678, 3'b111, 1'b0);
    tick();
    clearDones(0);
    numValid[0] = 1; num[0] = 32'hCAFE;
    for (int i = 0; i < 20; i++) begin
      chk("hold_ctrl", {26'd0, resValid[0], numReady[0], go[0], flags[0]}, {26'd0, 6'b100111});
      chk("hold_num", resNum[0], 32'h1234_5678);
      tick();
    end
    accept(0);
    send(0, 32'hCAFE);
    finishAll(0, 32'hCAFE, 3'b000);
    accept(0);
    chk("proc_after_4", {16'd0, procCnt[0]}, 32'd4);

    // reset in the middle of WAIT abandons the analysis
    send(0, 32'd77);
    tick();
    tick();
    rstN = 0;
    #1;
    checkZero(0, "midrst_A");
    tick();
    rstN = 1;
    tick();
    tick();
    send(0, 32'd99);
    finishAll(0, 32'd99, 3'b010);
    accept(0);
    chk("proc_after_reset", {16'd0, procCnt[0]}, 32'd1);

    // timeout on B: fib never reports
    send(1, 32'd5);
    pushExp(1, 32'd5, 3'b101, 1'b1);
    tick();
    for (int w = 1; w <= 8; w++) begin
      evenDone[1] = (w == 1);
      isEven[1]   = (w == 1);
      palDone[1]  = (w >= 3);
      isPal[1]    = (w >= 3);
      chk("to_no_valid", {31'd0, resValid[1]}, 32'd0);
      tick();
    end
    clearDones(1);
    chk("to_valid", {31'd0, resValid[1]}, 32'd1);
    accept(1);
    chk("to_cnt", {16'd0, toCnt[1]}, 32'd1);
    chk("to_proc", {16'd0, procCnt[1]}, 32'd1);

    // saturation on B (2-bit counters)
    for (int k = 1; k <= 5; k++) begin
      int e;
      send(1, 32'(100 + k));
      finishAll(1, 32'(100 + k), 3'b001);
      accept(1);
      e = (1 + k > 3) ? 3 : 1 + k;
      chk("sat_proc", {16'd0, procCnt[1]}, 32'(e));
`ifdef ANALYZER_SEQ_STATS_EN
      chk("sat_even", {16'd0, evenCntB}, 32'(e));
`endif
    end
    chk("sat_to_kept", {16'd0, toCnt[1]}, 32'd1);
`ifdef ANALYZER_SEQ_STATS_EN
    chk("stat_pal", {16'd0, palCntB}, 32'd1);
    chk("stat_fib", {16'd0, fibCntB}, 32'd0);
`endif

    repeat (3) tick();
    chk("scoreboard_empty", 32'(expA.size() + expB.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
